// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128 key expansion: one round key per clock into a 1408-bit round-key bus.
// Optional build macro AES_KS_ZEROIZE_EN adds a synchronous zeroize input.
module aes_key_schedule_seq (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
`ifdef AES_KS_ZEROIZE_EN
    input  logic           zeroize,
`endif
    input  logic [127:0]   key_in,
    output logic           busy,
    output logic           done,
    output logic           key_valid,
    output logic [1407:0]  round_keys
);
    localparam int unsigned NR  = 10;
    localparam int unsigned KW  = 128;
    localparam int unsigned RKW = KW * (NR + 1);
    localparam int unsigned CW  = 4;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, RUN} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    // One expansion step: previous round key to next round key.
    function automatic logic [KW-1:0] next_rk(input logic [KW-1:0] rk, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64]  ^ n0;
        n2 = rk[63:32]  ^ n1;
        n3 = rk[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [RKW-1:0]  rk_q, rk_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            kv_q, kv_d;
    logic            zero_c;
    logic            last_c;
    logic [10:0]     wr_base_c, rd_base_c;

`ifdef AES_KS_ZEROIZE_EN
    assign zero_c = zeroize;
`else
    assign zero_c = 1'b0;
`endif

    assign last_c    = (cnt_q == CW'(NR));
    assign wr_base_c = {cnt_q, 7'd0};
    assign rd_base_c = {cnt_q - 4'd1, 7'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = RUN;
            RUN:     if (last_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (zero_c) state_d = IDLE;
    end

    // Datapath and status next values; zeroize overrides everything.
    always_comb begin
        rk_d   = rk_q;
        cnt_d  = cnt_q;
        rcon_d = rcon_q;
        busy_d = busy_q;
        done_d = 1'b0;
        kv_d   = kv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rk_d[KW-1:0] = key_in;
                    cnt_d        = CW'(1);
                    rcon_d       = 8'h01;
                    busy_d       = 1'b1;
                    kv_d         = 1'b0;
                end
            end
            RUN: begin
                rk_d[wr_base_c +: KW] = next_rk(rk_q[rd_base_c +: KW], rcon_q);
                rcon_d = xtime(rcon_q);
                cnt_d  = cnt_q + CW'(1);
                if (last_c) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    kv_d   = 1'b1;
                end
            end
            default: ;
        endcase
        if (zero_c) begin
            rk_d   = '0;
            cnt_d  = '0;
            rcon_d = 8'h01;
            busy_d = 1'b0;
            done_d = 1'b0;
            kv_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_q   <= '0;
            cnt_q  <= '0;
            rcon_q <= 8'h01;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            kv_q   <= 1'b0;
        end else begin
            rk_q   <= rk_d;
            cnt_q  <= cnt_d;
            rcon_q <= rcon_d;
            busy_q <= busy_d;
            done_q <= done_d;
            kv_q   <= kv_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign key_valid  = kv_q;
    assign round_keys = rk_q;

endmodule
